// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer and CSR-port arbiter.
//
// Owns the single read/write port of the CSR register file and shares it
// between CSR instructions, system instructions (ebreak/ecall/mret) and the
// machine timer interrupt. Trap entry and mret are sequenced as multi-cycle
// read-modify-write updates of mepc/mcause/mstatus, ending in a one-cycle
// pipeline redirect.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   sys_inst_ctrl       00 none, 01 ebreak, 10 ecall, 11 mret
//   sys_pc, int_pc      PC of system instruction / oldest uncommitted insn
//   irq_timer           level machine timer interrupt (MTIP)
//   csr_inst_*          CSR instruction request (valid, op, idx, wdata)
//   csr_inst_rdata      old CSR value returned to rd
//   sys_ready           requester handshake, high only in IDLE
//   csr_read_addr/csr_write_addr/csr_write_data/csr_wen  CSR file port
//   csr_read_data       combinational read data from the CSR file
//   redirect_valid/pc   one-cycle flush + redirect to trap vector / mepc
//   ebreak_hit          one-cycle registered pulse after an accepted ebreak

module trap_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      sys_inst_ctrl,
  input  logic [XLEN-1:0] sys_pc,
  input  logic [XLEN-1:0] int_pc,
  input  logic            irq_timer,
  input  logic            csr_inst_valid,
  input  logic [1:0]      csr_inst_op,
  input  logic [XLEN-1:0] csr_inst_idx,
  input  logic [XLEN-1:0] csr_inst_wdata,
  output logic [XLEN-1:0] csr_inst_rdata,
  output logic            sys_ready,
  output logic [XLEN-1:0] csr_read_addr,
  output logic [XLEN-1:0] csr_write_addr,
  output logic [XLEN-1:0] csr_write_data,
  output logic            csr_wen,
  input  logic [XLEN-1:0] csr_read_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ebreak_hit
);

  // CSR addresses
  localparam logic [XLEN-1:0] ADDR_MSTATUS = XLEN'(12'h300);
  localparam logic [XLEN-1:0] ADDR_MIE     = XLEN'(12'h304);
  localparam logic [XLEN-1:0] ADDR_MTVEC   = XLEN'(12'h305);
  localparam logic [XLEN-1:0] ADDR_MEPC    = XLEN'(12'h341);
  localparam logic [XLEN-1:0] ADDR_MCAUSE  = XLEN'(12'h342);

  // Bit positions inside mstatus / mie
  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;
  localparam int unsigned MTIE_BIT = 7;

  // mcause values: environment call from M-mode, machine timer interrupt
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_IRQ   = {1'b1, (XLEN-1)'(7)};

  // System instruction encodings
  localparam logic [1:0] SYS_EBREAK = 2'b01;
  localparam logic [1:0] SYS_ECALL  = 2'b10;
  localparam logic [1:0] SYS_MRET   = 2'b11;

  // CSR instruction operations
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // FSM states
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_T_EPC    = 3'd1;
  localparam logic [2:0] S_T_CAUSE  = 3'd2;
  localparam logic [2:0] S_T_STATUS = 3'd3;
  localparam logic [2:0] S_T_VEC    = 3'd4;
  localparam logic [2:0] S_R_STATUS = 3'd5;
  localparam logic [2:0] S_R_EPC    = 3'd6;

  logic [2:0]      state_q,      state_d;
  logic            is_irq_q,     is_irq_d;
  logic [XLEN-1:0] epc_q,        epc_d;
  logic            sh_mie_q,     sh_mie_d;
  logic            sh_mtie_q,    sh_mtie_d;
  logic            ebreak_hit_q, ebreak_hit_d;

  logic            irq_pend;
  logic [XLEN-1:0] status_new;

  // Shadows mirror the enable bits so the interrupt check needs no CSR read
  assign irq_pend   = irq_timer & sh_mie_q & sh_mtie_q;
  assign ebreak_hit = ebreak_hit_q;

  // State and latched-context registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      is_irq_q     <= 1'b0;
      epc_q        <= '0;
      sh_mie_q     <= 1'b0;
      sh_mtie_q    <= 1'b0;
      ebreak_hit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_irq_q     <= is_irq_d;
      epc_q        <= epc_d;
      sh_mie_q     <= sh_mie_d;
      sh_mtie_q    <= sh_mtie_d;
      ebreak_hit_q <= ebreak_hit_d;
    end
  end

  // Arbitration, sequencing and CSR-port drive
  always_comb begin
    state_d        = state_q;
    is_irq_d       = is_irq_q;
    epc_d          = epc_q;
    sh_mie_d       = sh_mie_q;
    sh_mtie_d      = sh_mtie_q;
    ebreak_hit_d   = 1'b0;
    status_new     = '0;
    sys_ready      = 1'b0;
    csr_inst_rdata = '0;
    csr_read_addr  = '0;
    csr_write_addr = '0;
    csr_write_data = '0;
    csr_wen        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    case (state_q)
      S_IDLE: begin
        // A pending interrupt pre-empts every requester, so nobody sees ready
        sys_ready = ~irq_pend;
        if (irq_pend) begin
          is_irq_d = 1'b1;
          epc_d    = int_pc;
          state_d  = S_T_EPC;
        end else if (sys_inst_ctrl != 2'b00) begin
          case (sys_inst_ctrl)
            SYS_EBREAK: ebreak_hit_d = 1'b1;
            SYS_ECALL: begin
              is_irq_d = 1'b0;
              epc_d    = sys_pc;
              state_d  = S_T_EPC;
            end
            SYS_MRET: state_d = S_R_STATUS;
            default: ;
          endcase
        end else if (csr_inst_valid) begin
          csr_read_addr  = csr_inst_idx;
          csr_write_addr = csr_inst_idx;
          csr_inst_rdata = csr_read_data;
          csr_wen        = (csr_inst_op != OP_READ);
          case (csr_inst_op)
            OP_WRITE: csr_write_data = csr_inst_wdata;
            OP_SET:   csr_write_data = csr_read_data | csr_inst_wdata;
            OP_CLEAR: csr_write_data = csr_read_data & ~csr_inst_wdata;
            default:  csr_write_data = '0;
          endcase
        end
      end

      S_T_EPC: begin
        csr_write_addr = ADDR_MEPC;
        csr_write_data = epc_q;
        csr_wen        = 1'b1;
        state_d        = S_T_CAUSE;
      end

      S_T_CAUSE: begin
        csr_write_addr = ADDR_MCAUSE;
        csr_write_data = is_irq_q ? CAUSE_IRQ : CAUSE_ECALL;
        csr_wen        = 1'b1;
        state_d        = S_T_STATUS;
      end

      // Trap entry: stash MIE in MPIE and mask interrupts
      S_T_STATUS: begin
        status_new           = csr_read_data;
        status_new[MPIE_BIT] = csr_read_data[MIE_BIT];
        status_new[MIE_BIT]  = 1'b0;
        csr_read_addr        = ADDR_MSTATUS;
        csr_write_addr       = ADDR_MSTATUS;
        csr_write_data       = status_new;
        csr_wen              = 1'b1;
        state_d              = S_T_VEC;
      end

      // Direct mode only: the mode field in mtvec[1:0] is dropped
      S_T_VEC: begin
        csr_read_addr  = ADDR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_read_data[XLEN-1:2], 2'b00};
        state_d        = S_IDLE;
      end

      // Trap return: restore MIE from MPIE and set MPIE
      S_R_STATUS: begin
        status_new           = csr_read_data;
        status_new[MIE_BIT]  = csr_read_data[MPIE_BIT];
        status_new[MPIE_BIT] = 1'b1;
        csr_read_addr        = ADDR_MSTATUS;
        csr_write_addr       = ADDR_MSTATUS;
        csr_write_data       = status_new;
        csr_wen              = 1'b1;
        state_d              = S_R_EPC;
      end

      S_R_EPC: begin
        csr_read_addr  = ADDR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_read_data;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // While reset is held the port is quiet, so an abandoned sequence
    // cannot land a write or a redirect on the reset edge
    if (!rst) begin
      csr_inst_rdata = '0;
      csr_read_addr  = '0;
      csr_write_addr = '0;
      csr_write_data = '0;
      csr_wen        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end

    // Every CSR write passes through here, keeping the shadows exact
    if (csr_wen && (csr_write_addr == ADDR_MSTATUS)) begin
      sh_mie_d = csr_write_data[MIE_BIT];
    end
    if (csr_wen && (csr_write_addr == ADDR_MIE)) begin
      sh_mtie_d = csr_write_data[MTIE_BIT];
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: directed test-plan scenarios followed by random
// traffic. An architectural CSR model predicts every port write, rd value,
// redirect and ebreak pulse (with its cycle) into a queue; a monitor process
// pops and compares whenever the DUT presents one of those events.

module tb_trap_ctrl;

  localparam logic [31:0] A_MSTATUS  = 32'h300;
  localparam logic [31:0] A_MIE      = 32'h304;
  localparam logic [31:0] A_MTVEC    = 32'h305;
  localparam logic [31:0] A_MSCRATCH = 32'h340;
  localparam logic [31:0] A_MEPC     = 32'h341;
  localparam logic [31:0] A_MCAUSE   = 32'h342;

  localparam int EV_RD = 0, EV_WR = 1, EV_RED = 2, EV_EB = 3;
  localparam int K_NONE = 0, K_CSR = 1, K_EBREAK = 2, K_ECALL = 3, K_MRET = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];

  logic        clk;
  logic        rst;
  logic [1:0]  sys_inst_ctrl;
  logic [31:0] sys_pc;
  logic [31:0] int_pc;
  logic        irq_timer;
  logic        csr_inst_valid;
  logic [1:0]  csr_inst_op;
  logic [31:0] csr_inst_idx;
  logic [31:0] csr_inst_wdata;
  logic [31:0] csr_inst_rdata;
  logic        sys_ready;
  logic [31:0] csr_read_addr;
  logic [31:0] csr_write_addr;
  logic [31:0] csr_write_data;
  logic        csr_wen;
  logic [31:0] csr_read_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ebreak_hit;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // CSR file behind the port, and the architectural reference state
  logic [31:0] csr_file [0:6] = '{default: '0};
  logic [31:0] ref_csr  [0:6] = '{default: '0};
  bit ref_sh_mie  = 1'b0;
  bit ref_sh_mtie = 1'b0;

  trap_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .sys_inst_ctrl  (sys_inst_ctrl),
    .sys_pc         (sys_pc),
    .int_pc         (int_pc),
    .irq_timer      (irq_timer),
    .csr_inst_valid (csr_inst_valid),
    .csr_inst_op    (csr_inst_op),
    .csr_inst_idx   (csr_inst_idx),
    .csr_inst_wdata (csr_inst_wdata),
    .csr_inst_rdata (csr_inst_rdata),
    .sys_ready      (sys_ready),
    .csr_read_addr  (csr_read_addr),
    .csr_write_addr (csr_write_addr),
    .csr_write_data (csr_write_data),
    .csr_wen        (csr_wen),
    .csr_read_data  (csr_read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ebreak_hit     (ebreak_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int slot(input logic [31:0] a);
    case (a)
      A_MSTATUS:  return 0;
      A_MIE:      return 1;
      A_MTVEC:    return 2;
      A_MEPC:     return 3;
      A_MCAUSE:   return 4;
      A_MSCRATCH: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic logic [31:0] pick_addr(input int r);
    case (r)
      0: return A_MSTATUS;
      1: return A_MIE;
      2: return A_MTVEC;
      3: return A_MEPC;
      4: return A_MCAUSE;
      default: return A_MSCRATCH;
    endcase
  endfunction

  always_comb csr_read_data = csr_file[slot(csr_read_addr)];

  always @(posedge clk) begin
    if (csr_wen && slot(csr_write_addr) < 6) csr_file[slot(csr_write_addr)] <= csr_write_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{k, c, a, d});
  endtask

  // Architectural effect of a CSR write issued by the sequencer or an insn
  task automatic ref_wr(input int c, input logic [31:0] a, input logic [31:0] d);
    push(EV_WR, c, a, d);
    if (slot(a) < 6) ref_csr[slot(a)] = d;
    if (a == A_MSTATUS) ref_sh_mie = d[3];
    if (a == A_MIE) ref_sh_mtie = d[7];
  endtask

  task automatic model_csr(input int c0, input logic [1:0] op, input logic [31:0] idx,
                           input logic [31:0] wd);
    logic [31:0] old;
    logic [31:0] nv;
    old = ref_csr[slot(idx)];
    push(EV_RD, c0, idx, old);
    if (op != 2'b00) begin
      nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
      ref_wr(c0, idx, nv);
    end
  endtask

  task automatic model_trap(input int c0, input bit is_irq, input logic [31:0] epc);
    logic [31:0] st;
    ref_wr(c0 + 1, A_MEPC, epc);
    ref_wr(c0 + 2, A_MCAUSE, is_irq ? 32'h8000_0007 : 32'd11);
    st = ref_csr[0];
    st[7] = st[3];
    st[3] = 1'b0;
    ref_wr(c0 + 3, A_MSTATUS, st);
    push(EV_RED, c0 + 4, 32'h0, ref_csr[2] & 32'hFFFF_FFFC);
  endtask

  task automatic model_mret(input int c0);
    logic [31:0] st;
    st = ref_csr[0];
    st[3] = st[7];
    st[7] = 1'b1;
    ref_wr(c0 + 1, A_MSTATUS, st);
    push(EV_RED, c0 + 2, 32'h0, ref_csr[3]);
  endtask

  // Monitor: pops the oldest expected event whenever the DUT shows one
  task automatic observe(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d addr=%h data=%h, none expected",
               k, cyc, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.addr !== a || e.data !== d) begin
        n_fail++;
        $display("FAIL event_compare: got kind=%0d cyc=%0d addr=%h data=%h, expected kind=%0d cyc=%0d addr=%h data=%h",
                 k, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
      end
    end
  endtask

  task automatic monitor_loop();
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst && csr_inst_valid && sys_ready && sys_inst_ctrl == 2'b00)
          observe(EV_RD, csr_read_addr, csr_inst_rdata);
        if (csr_wen) observe(EV_WR, csr_write_addr, csr_write_data);
        if (redirect_valid) observe(EV_RED, 32'h0, redirect_pc);
        if (ebreak_hit) observe(EV_EB, 32'h0, 32'h0);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          n_chk++;
          n_fail++;
          $display("FAIL missing_event: got nothing, expected kind=%0d cyc=%0d addr=%h data=%h",
                   e.kind, e.cyc, e.addr, e.data);
        end
      end
    end
  endtask

  // Drive one request, predict its outcome, wait for completion
  task automatic issue(input int kind, input logic [1:0] op, input logic [31:0] idx,
                       input logic [31:0] wd, input logic [31:0] pc, input logic [31:0] ipc,
                       input bit irq, input bit keep_irq);
    int c0;
    bit pend;
    bit long_seq;
    bit got;
    @(posedge clk);
    #1;
    c0 = cyc;
    irq_timer = irq;
    int_pc = ipc;
    sys_pc = pc;
    case (kind)
      K_CSR: begin
        csr_inst_valid = 1'b1;
        csr_inst_op    = op;
        csr_inst_idx   = idx;
        csr_inst_wdata = wd;
      end
      K_EBREAK: sys_inst_ctrl = 2'b01;
      K_ECALL:  sys_inst_ctrl = 2'b10;
      K_MRET:   sys_inst_ctrl = 2'b11;
      default: ;
    endcase
    pend = irq && ref_sh_mie && ref_sh_mtie;
    long_seq = 1'b0;
    if (pend) begin
      model_trap(c0, 1'b1, ipc);
      long_seq = 1'b1;
    end else begin
      case (kind)
        K_CSR:    model_csr(c0, op, idx, wd);
        K_EBREAK: push(EV_EB, c0 + 1, 32'h0, 32'h0);
        K_ECALL:  begin model_trap(c0, 1'b0, pc); long_seq = 1'b1; end
        K_MRET:   begin model_mret(c0); long_seq = 1'b1; end
        default: ;
      endcase
    end
    @(negedge clk);
    chk("sys_ready_at_request", 32'(sys_ready), 32'(!pend));
    if (long_seq) begin
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        if (redirect_valid) got = 1'b1;
      end
      chk("redirect_within_bound", 32'(got), 32'd1);
    end
    @(posedge clk);
    #1;
    csr_inst_valid = 1'b0;
    csr_inst_op    = 2'b00;
    csr_inst_idx   = '0;
    csr_inst_wdata = '0;
    sys_inst_ctrl  = 2'b00;
    if (!keep_irq) irq_timer = 1'b0;
  endtask

  initial begin
    int c0;
    int r;
    logic [31:0] v;
    logic [31:0] p;
    rst = 1'b0;
    sys_inst_ctrl = 2'b00;
    sys_pc = '0;
    int_pc = '0;
    irq_timer = 1'b0;
    csr_inst_valid = 1'b0;
    csr_inst_op = 2'b00;
    csr_inst_idx = '0;
    csr_inst_wdata = '0;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sys_ready", 32'(sys_ready), 32'd1);
    chk("reset_csr_wen", 32'(csr_wen), 32'd0);
    chk("reset_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("reset_ebreak_hit", 32'(ebreak_hit), 32'd0);
    chk("reset_write_addr", csr_write_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // ecall entry with mtvec=0x8000_0100, mstatus=0x8
    issue(K_CSR, 2'b01, A_MTVEC, 32'h8000_0100, 0, 0, 0, 0);
    issue(K_CSR, 2'b01, A_MSTATUS, 32'h0000_0008, 0, 0, 0, 0);
    issue(K_ECALL, 2'b00, 0, 0, 32'h8000_0010, 32'h0, 0, 0);

    // mret with mepc=0x8000_0014, mstatus=0x80
    issue(K_CSR, 2'b01, A_MEPC, 32'h8000_0014, 0, 0, 0, 0);
    issue(K_MRET, 2'b00, 0, 0, 0, 0, 0, 0);

    // Enable MTIE, then csrrc clears MIE: irq must not be taken
    issue(K_CSR, 2'b10, A_MIE, 32'h0000_0080, 0, 0, 0, 0);
    issue(K_CSR, 2'b11, A_MSTATUS, 32'h0000_0008, 0, 0, 0, 0);
    issue(K_NONE, 2'b00, 0, 0, 0, 32'h0000_0200, 1, 0);

    // Set MIE, timer interrupt taken once while irq_timer stays high
    issue(K_CSR, 2'b10, A_MSTATUS, 32'h0000_0008, 0, 0, 0, 0);
    issue(K_NONE, 2'b00, 0, 0, 0, 32'h0000_0200, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("irq_held_no_reentry", 32'(sys_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    irq_timer = 1'b0;
    issue(K_MRET, 2'b00, 0, 0, 0, 0, 0, 0);

    // Interrupt beats a CSR write in the same cycle
    issue(K_CSR, 2'b01, A_MSCRATCH, 32'hDEAD_BEEF, 0, 32'h0000_0300, 1, 0);
    issue(K_MRET, 2'b00, 0, 0, 0, 0, 0, 0);

    // Interrupt beats ecall; mepc is int_pc so the ecall re-executes
    issue(K_ECALL, 2'b00, 0, 0, 32'h8000_0020, 32'h8000_0020, 1, 0);
    issue(K_MRET, 2'b00, 0, 0, 0, 0, 0, 0);

    issue(K_EBREAK, 2'b00, 0, 0, 0, 0, 0, 0);

    // Reset while in T_CAUSE: mepc lands, nothing after it
    @(posedge clk);
    #1;
    c0 = cyc;
    sys_pc = 32'h8000_0040;
    sys_inst_ctrl = 2'b10;
    ref_wr(c0 + 1, A_MEPC, 32'h8000_0040);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sys_inst_ctrl = 2'b00;
    ref_sh_mie = 1'b0;
    ref_sh_mtie = 1'b0;
    @(negedge clk);
    chk("rst_mid_seq_wen", 32'(csr_wen), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_sys_ready", 32'(sys_ready), 32'd1);
    chk("post_rst_redirect", 32'(redirect_valid), 32'd0);
    chk("post_rst_ebreak_hit", 32'(ebreak_hit), 32'd0);
    issue(K_EBREAK, 2'b00, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      r = int'($urandom_range(0, 9));
      v = $urandom;
      p = $urandom;
      p = p & 32'hFFFF_FFFC;
      if (r <= 5)
        issue(K_CSR, 2'($urandom_range(0, 3)), pick_addr(int'($urandom_range(0, 5))), v, 0, p,
              ($urandom_range(0, 7) == 0), 0);
      else if (r == 6) issue(K_EBREAK, 2'b00, 0, 0, 0, p, ($urandom_range(0, 7) == 0), 0);
      else if (r == 7) issue(K_ECALL, 2'b00, 0, 0, p, v & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0), 0);
      else if (r == 8) issue(K_MRET, 2'b00, 0, 0, 0, p, ($urandom_range(0, 7) == 0), 0);
      else issue(K_NONE, 2'b00, 0, 0, 0, p, 1, 0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 6; s++) chk("final_csr_file", csr_file[s], ref_csr[s]);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
